// File: rtl/wts_channel_sequencer.sv
// Time-multiplexed channel selector: one registered channel value per enable tick.
// Optional build macro WTS_SEQ_SKIP_MASKED_EN makes masked channels consume no ticks.
module wts_channel_sequencer #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 5,
  parameter int AW       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [BITS*CHANNELS-1:0] regs,
  input  logic [CHANNELS-1:0]      mask,
  output logic [AW-1:0]            active,
  output logic [BITS-1:0]          result,
  output logic                     valid,
  output logic                     frame_start
);

  localparam logic [AW-1:0] LAST = AW'(CHANNELS - 1);
  localparam int            IW   = AW + 1;

  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   r_active;
  logic [BITS-1:0] r_result;
  logic            r_valid;
  logic            r_frame_start;

  logic [AW-1:0]   w_sel;
  logic            w_hit;
  logic [BITS-1:0] w_value;

`ifdef WTS_SEQ_SKIP_MASKED_EN
  logic [IW-1:0] w_idx;

  // Rotated priority search: walk offsets from the far end back to ptr so the
  // nearest active channel at or after ptr overwrites any further candidate.
  always_comb begin
    w_sel = r_ptr;
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + IW'(k);
      if (w_idx >= IW'(CHANNELS)) w_idx = w_idx - IW'(CHANNELS);
      if (mask[w_idx[AW-1:0]]) begin
        w_sel = w_idx[AW-1:0];
        w_hit = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_sel = r_ptr;
    w_hit = 1'b1;
  end
`endif

  always_comb begin
    w_value = '0;
    if (mask[w_sel]) w_value = regs[int'(w_sel)*BITS +: BITS];
  end

  // valid: one-cycle strobe, no backpressure; result/active changed on this
  // edge. frame_start rides on valid when the selection wrapped through slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= '0;
      r_active      <= '0;
      r_result      <= '0;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (enable && w_hit) begin
      r_active      <= w_sel;
      r_result      <= w_value;
      r_valid       <= 1'b1;
      r_frame_start <= (r_ptr == '0) || (w_sel < r_ptr);
      r_ptr         <= (w_sel == LAST) ? '0 : w_sel + 1'b1;
    end else begin
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign active      = r_active;
  assign result      = r_result;
  assign valid       = r_valid;
  assign frame_start = r_frame_start;

endmodule

// File: doc/wts_channel_sequencer.md
# wts_channel_sequencer

Parametrised, time-multiplexed channel selector for the wave table sound engine. It holds a slot pointer, and on each `enable` tick it picks one of `CHANNELS` per-channel register values and presents it registered on `result`. Alongside the value it reports the channel index, a valid strobe and a frame-start strobe. It sits between the per-channel register banks and the shared mixer/volume datapath, and gives that datapath its channel rotation.

## Interface
Parameters:
- `BITS`, 8, width of each channel value.
- `CHANNELS`, 5, number of channels; legal range 2..8.
- `AW`, 3, width of channel index; must satisfy 2**AW >= CHANNELS.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  advance tick; one slot is output per cycle in which it is high.
- `regs`  in  BITS*CHANNELS  flat channel values; channel n occupies `[n*BITS +: BITS]`.
- `mask`  in  CHANNELS  per-channel enable; bit n = 1 means channel n is active.
- `active`  out  AW  index of the channel currently on `result`.
- `result`  out  BITS  registered selected value.
- `valid`  out  1  one-cycle pulse; `result`/`active` were updated this cycle.
- `frame_start`  out  1  one-cycle pulse, coincident with `valid`; this slot begins a new rotation.

## Operation
- Internal pointer `ptr` (AW bits) holds the next slot to output.
- Reset (sampled at the clock edge) sets the following:
  - `ptr`=0, `active`=0, `result`=0, `valid`=0, `frame_start`=0.
  - Reset wins over a simultaneous `enable`.
- On a cycle with `enable`=1, compute `sel` as follows:
  - Normal build: `sel`=`ptr`.
  - Skip build: see Configuration.
- Registered updates on that edge:
  - `active`<=`sel`.
  - `result`<=`regs[sel]` if `mask[sel]`=1, else 0.
  - `valid`<=1.
  - `ptr`<=`sel`+1, wrapping to 0 when `sel`=CHANNELS-1. The pointer never takes values >= CHANNELS.
- `frame_start`<=1 when `ptr`=0 or `sel`<`ptr` (the slot selection wrapped through channel 0); otherwise 0.
- On a cycle with `enable`=0:
  - `valid` and `frame_start` go to 0.
  - `active`, `result` and `ptr` hold.
- `regs` and `mask` are sampled only on the `enable` edge. Changes between ticks take effect at the next tick, and a change mid-rotation does not restart the frame.
- Back-to-back `enable` is legal; one slot is output per cycle.

## Timing
- Latency: 1 cycle from the `enable` edge to `result`/`active`/`valid`.
- No combinational path from any input to any output; all outputs are registered.
- Rotation period with `enable` held high: CHANNELS cycles in the normal build.
- `valid` is never high for two cycles unless `enable` was high for two consecutive cycles.

## Configuration
Macro `WTS_SEQ_SKIP_MASKED_EN`.
- Not defined:
  - Every slot is visited in order 0..CHANNELS-1.
  - A masked slot outputs `result`=0 with `valid`=1.
- Defined:
  - `sel` is the first index with `mask`=1, searching circularly from `ptr` and including `ptr`.
  - Masked slots consume no ticks.
  - If `mask` is all zero, the tick is ignored: `valid`=0, `frame_start`=0, and all state holds.
  - Implemented as a rotated priority search; it must remain single-cycle.

## Test plan
- Reset then `enable` high 6 cycles, CHANNELS=5, BITS=8, `regs`={ch0=0x10, ch1=0x21, ch2=0x32, ch3=0x43, ch4=0x54}, `mask`=5'b11111.
  - `result` sequence is 0x10,0x21,0x32,0x43,0x54,0x10.
  - `active` sequence is 0,1,2,3,4,0.
  - `frame_start` is high on the 1st and 6th outputs.
- `enable` pulsed every 3rd cycle:
  - `valid` is high exactly one cycle after each pulse.
  - `result` holds between pulses.
- `mask`=5'b10101, normal build, 5 ticks:
  - `result`=0x10,0,0x32,0,0x54.
  - `valid`=1 on all five ticks.
- Same mask, `WTS_SEQ_SKIP_MASKED_EN` defined, 4 ticks:
  - `active`=0,2,4,0.
  - `frame_start` high on the 1st and 4th ticks.
- Skip build with `mask`=0 for 3 ticks, then `mask`=5'b01000:
  - No `valid` during the 3 ticks.
  - The next tick gives `active`=3, `result`=0x43.
- Assert `reset` together with `enable` at slot 3:
  - Next cycle has all outputs 0.
  - The following `enable` outputs channel 0 with `frame_start`=1.
